// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the 16-bit multi-cycle CPU control path.
//   word_size / op_size : datapath width and opcode / ALU-select width
//   OP_*                : instruction opcodes (ir[15:12])
//   state_t             : control FSM states
//   cls_t               : instruction class produced by ctrl_decode
package cpu_defs;

  localparam int word_size = 16;
  localparam int op_size   = 4;

  localparam logic [op_size-1:0] OP_LW   = 4'b0001;
  localparam logic [op_size-1:0] OP_LB   = 4'b0010;
  localparam logic [op_size-1:0] OP_SW   = 4'b0011;
  localparam logic [op_size-1:0] OP_SB   = 4'b0100;
  localparam logic [op_size-1:0] OP_AND  = 4'b0101;
  localparam logic [op_size-1:0] OP_OR   = 4'b0110;
  localparam logic [op_size-1:0] OP_ADD  = 4'b0111;
  localparam logic [op_size-1:0] OP_SUB  = 4'b1000;
  localparam logic [op_size-1:0] OP_SLT  = 4'b1001;
  localparam logic [op_size-1:0] OP_BEQ  = 4'b1010;
  localparam logic [op_size-1:0] OP_JUMP = 4'b1011;
  localparam logic [op_size-1:0] OP_ADDI = 4'b1100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  // ADDI shares CLS_RTYPE: both finish with a register write of alu_out.
  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_ILLEGAL
  } cls_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder.
//   opcode    : ir[15:12]
//   alu_sel   : ALU operation for this instruction
//   alu_b_imm : 1 = ALU operand B is the sign-extended immediate
//   cls       : instruction class driving the FSM path
//   rf_wsel   : register write source, 1 = memory read data
//   waddr_rt  : 1 = destination is ir[7:4], 0 = ir[3:0]
//   byte_op   : 1 = byte-wide memory access
module ctrl_decode
  import cpu_defs::*;
(
  input  logic [op_size-1:0] opcode,
  output logic [op_size-1:0] alu_sel,
  output logic               alu_b_imm,
  output cls_t               cls,
  output logic               rf_wsel,
  output logic               waddr_rt,
  output logic               byte_op
);

  always_comb begin
    alu_sel   = OP_ADD;
    alu_b_imm = 1'b0;
    cls       = CLS_ILLEGAL;
    rf_wsel   = 1'b0;
    waddr_rt  = 1'b0;
    byte_op   = 1'b0;
    case (opcode)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: begin
        alu_sel = opcode;
        cls     = CLS_RTYPE;
      end
      OP_ADDI: begin
        alu_b_imm = 1'b1;
        cls       = CLS_RTYPE;
        waddr_rt  = 1'b1;
      end
      OP_LW, OP_LB: begin
        alu_b_imm = 1'b1;
        cls       = CLS_LOAD;
        rf_wsel   = 1'b1;
        waddr_rt  = 1'b1;
        byte_op   = (opcode == OP_LB);
      end
      OP_SW, OP_SB: begin
        alu_b_imm = 1'b1;
        cls       = CLS_STORE;
        byte_op   = (opcode == OP_SB);
      end
      OP_BEQ: begin
        // Equality is tested as rs - rt == 0 via the zero flag.
        alu_sel = OP_SUB;
        cls     = CLS_BRANCH;
      end
      OP_JUMP: begin
        cls = CLS_JUMP;
      end
      default: begin
        cls = CLS_ILLEGAL;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit for the 16-bit CPU (sits directly upstream of the ALU).
// Fetches over the shared memory port, holds PC/IR, decodes and sequences
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
//   clk, rst_n           : clock (rising edge), synchronous active-low reset
//   mem_*                : shared memory port (req/ready handshake, wait states allowed)
//   alu_out, alu_zero_flag : ALU result and zero flag from the datapath
//   alu_sel, alu_b_imm, imm_ext : ALU operation, operand-B mux, immediate
//   rf_*                 : register-file read addresses, write strobe/address/source
//   pc, ir               : program counter (word-addressed) and instruction register
//   illegal              : sticky illegal-opcode flag (held until reset)
module multicycle_ctrl #(
  parameter int word_size     = 16,
  parameter int op_size       = 4,
  parameter int reg_addr_size = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic                     mem_byte,
  output logic [word_size-1:0]     mem_addr,
  input  logic                     mem_ready,
  input  logic [word_size-1:0]     mem_rdata,
  input  logic [word_size-1:0]     alu_out,
  input  logic                     alu_zero_flag,
  output logic [op_size-1:0]       alu_sel,
  output logic                     alu_b_imm,
  output logic [word_size-1:0]     imm_ext,
  output logic [reg_addr_size-1:0] rf_raddr1,
  output logic [reg_addr_size-1:0] rf_raddr2,
  output logic                     rf_we,
  output logic [reg_addr_size-1:0] rf_waddr,
  output logic                     rf_wsel,
  output logic [word_size-1:0]     pc,
  output logic [word_size-1:0]     ir,
  output logic                     illegal
);
  import cpu_defs::*;

  state_t state, state_nxt;
  cls_t   cls_q;
  logic   byte_q;

  logic [op_size-1:0] dec_alu_sel;
  logic               dec_alu_b_imm;
  cls_t               dec_cls;
  logic               dec_rf_wsel;
  logic               dec_waddr_rt;
  logic               dec_byte_op;

  ctrl_decode u_decode (
    .opcode    (ir[word_size-1 -: op_size]),
    .alu_sel   (dec_alu_sel),
    .alu_b_imm (dec_alu_b_imm),
    .cls       (dec_cls),
    .rf_wsel   (dec_rf_wsel),
    .waddr_rt  (dec_waddr_rt),
    .byte_op   (dec_byte_op)
  );

  assign imm_ext   = {{(word_size-4){ir[3]}}, ir[3:0]};
  assign rf_raddr1 = ir[11:8];
  assign rf_raddr2 = ir[7:4];

  // State, PC/IR and the decoded controls registered at DECODE, which then
  // stay stable until the next DECODE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc        <= '0;
      ir        <= '0;
      alu_sel   <= '0;
      alu_b_imm <= 1'b0;
      rf_waddr  <= '0;
      rf_wsel   <= 1'b0;
      cls_q     <= CLS_RTYPE;
      byte_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + word_size'(1);
          end
        end
        ST_DECODE: begin
          alu_sel   <= dec_alu_sel;
          alu_b_imm <= dec_alu_b_imm;
          rf_wsel   <= dec_rf_wsel;
          rf_waddr  <= dec_waddr_rt ? ir[7:4] : ir[3:0];
          cls_q     <= dec_cls;
          byte_q    <= dec_byte_op;
        end
        ST_EXEC: begin
          // pc already points past this instruction.
          if (cls_q == CLS_BRANCH && alu_zero_flag) begin
            pc <= pc + imm_ext;
          end else if (cls_q == CLS_JUMP) begin
            pc <= {pc[word_size-1 -: 4], ir[word_size-5:0]};
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_byte  = 1'b0;
    mem_addr  = pc;
    rf_we     = 1'b0;
    illegal   = 1'b0;
    case (state)
      ST_IDLE: begin
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        state_nxt = (dec_cls == CLS_ILLEGAL) ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_BRANCH, CLS_JUMP: state_nxt = ST_FETCH;
          CLS_LOAD, CLS_STORE:  state_nxt = ST_MEM;
          default:              state_nxt = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_addr = alu_out;
        mem_we   = (cls_q == CLS_STORE);
        mem_byte = byte_q;
        if (mem_ready) state_nxt = (cls_q == CLS_LOAD) ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        rf_we     = 1'b1;
        state_nxt = ST_FETCH;
      end
      ST_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_we, mem_byte, mem_ready;
  logic [15:0] mem_addr, mem_rdata, alu_out, imm_ext, pc, ir;
  logic        alu_zero_flag, alu_b_imm, rf_we, rf_wsel, illegal;
  logic [3:0]  alu_sel, rf_raddr1, rf_raddr2, rf_waddr;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_pc;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_byte      (mem_byte),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .alu_out       (alu_out),
    .alu_zero_flag (alu_zero_flag),
    .alu_sel       (alu_sel),
    .alu_b_imm     (alu_b_imm),
    .imm_ext       (imm_ext),
    .rf_raddr1     (rf_raddr1),
    .rf_raddr2     (rf_raddr2),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wsel       (rf_wsel),
    .pc            (pc),
    .ir            (ir),
    .illegal       (illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // ISA-level instruction class: 0 illegal, 1 reg-write ALU op, 2 load,
  // 3 store, 4 branch, 5 jump.
  function automatic int cls_of(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2) return 2;
    if (op == 4'd3 || op == 4'd4) return 3;
    if ((op >= 4'd5 && op <= 4'd9) || op == 4'd12) return 1;
    if (op == 4'd10) return 4;
    if (op == 4'd11) return 5;
    return 0;
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    step();
    step();
    rst_n  = 1'b1;
    exp_pc = 16'h0000;
    chk("rst_mem_req", {15'd0, mem_req}, 16'd0);
    chk("rst_pc", pc, 16'h0000);
  endtask

  // Waits for the fetch request, serves it after fw wait states; returns in
  // the DECODE cycle.
  task automatic fetch_instr(input logic [15:0] instr, input int fw, output int cyc);
    int n;
    n = 0;
    cyc = 0;
    while (!mem_req && n < 20) begin
      step();
      n++;
    end
    chk("fetch_req", {15'd0, mem_req}, 16'd1);
    chk("fetch_addr", mem_addr, exp_pc);
    chk("fetch_we_byte", {14'd0, mem_we, mem_byte}, 16'd0);
    for (int i = 0; i < fw; i++) begin
      mem_ready = 1'b0;
      mem_rdata = 16'($urandom);
      step();
      cyc++;
      chk("fetch_hold_addr", mem_addr, exp_pc);
      chk("fetch_hold_req", {15'd0, mem_req}, 16'd1);
    end
    mem_ready = 1'b1;
    mem_rdata = instr;
    step();
    cyc++;
    mem_ready = 1'b0;
    chk("ir_load", ir, instr);
    chk("pc_incr", pc, exp_pc + 16'd1);
  endtask

  task automatic run_instr(input logic [15:0] instr, input logic zero, input int fw, input int mw);
    logic [3:0]  op;
    int          c, cyc, n, mcnt, wecnt, exp_cyc;
    logic        done, mdone, exp_mem;
    logic [15:0] pc1, imm, npc, alu_val;
    logic [3:0]  exp_sel, exp_waddr;
    logic        exp_bimm;

    op      = instr[15:12];
    c       = cls_of(op);
    exp_mem = (c == 2 || c == 3);
    pc1     = exp_pc + 16'd1;
    imm     = {{12{instr[3]}}, instr[3:0]};
    if (c == 4 && zero)  npc = pc1 + imm;
    else if (c == 5)     npc = {pc1[15:12], instr[11:0]};
    else                 npc = pc1;
    exp_cyc = (c == 2) ? 5 : (c == 1 || c == 3) ? 4 : 3;
    exp_cyc = exp_cyc + fw + (exp_mem ? mw : 0);
    exp_sel   = (c == 1 && op != 4'd12) ? op : (c == 4) ? 4'd8 : 4'd7;
    exp_bimm  = (c == 2 || c == 3 || op == 4'd12);
    exp_waddr = (c == 1 && op != 4'd12) ? instr[3:0] : instr[7:4];

    alu_val       = 16'($urandom);
    alu_out       = alu_val;
    alu_zero_flag = zero;

    fetch_instr(instr, fw, cyc);
    done = 1'b0; mdone = 1'b0; mcnt = 0; wecnt = 0; n = 0;
    while (!done && n < 40) begin
      mem_ready = 1'b0;
      if (mem_req) begin
        if (exp_mem && !mdone) begin
          chk("mem_addr", mem_addr, alu_val);
          chk("mem_we", {15'd0, mem_we}, {15'd0, c == 3});
          chk("mem_byte", {15'd0, mem_byte}, {15'd0, op == 4'd2 || op == 4'd4});
          if (mcnt < mw) begin
            mcnt++;
          end else begin
            mem_ready = 1'b1;
            mem_rdata = 16'($urandom);
            mdone     = 1'b1;
          end
        end else begin
          done = 1'b1;
        end
      end
      if (rf_we) begin
        wecnt++;
        chk("rf_waddr", {12'd0, rf_waddr}, {12'd0, exp_waddr});
        chk("rf_wsel", {15'd0, rf_wsel}, {15'd0, c == 2});
        chk("wb_no_req", {15'd0, mem_req}, 16'd0);
      end
      if (!done) begin
        step();
        cyc++;
        n++;
      end
    end
    mem_ready = 1'b0;
    chk("next_fetch_req", {15'd0, mem_req}, 16'd1);
    chk("mem_done", {15'd0, mdone}, {15'd0, exp_mem});
    chk("cycles", 16'(cyc), 16'(exp_cyc));
    chk("rf_we_pulses", 16'(wecnt), (c == 1 || c == 2) ? 16'd1 : 16'd0);
    chk("pc_next", pc, npc);
    chk("next_fetch_addr", mem_addr, npc);
    if (c != 5) begin
      chk("alu_sel", {12'd0, alu_sel}, {12'd0, exp_sel});
      chk("alu_b_imm", {15'd0, alu_b_imm}, {15'd0, exp_bimm});
    end
    exp_pc = npc;
  endtask

  initial begin
    int          cyc;
    logic [15:0] instr;
    logic [3:0]  op;

    rst_n = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0;
    alu_out = 16'h0; alu_zero_flag = 1'b0; exp_pc = 16'h0;
    step();
    step();
    chk("reset_pc", pc, 16'h0000);
    chk("reset_ir", ir, 16'h0000);
    chk("reset_alu_sel", {12'd0, alu_sel}, 16'd0);
    chk("reset_strobes", {12'd0, mem_req, mem_we, rf_we, illegal}, 16'd0);
    rst_n = 1'b1;
    chk("idle_no_req", {15'd0, mem_req}, 16'd0);

    // ADD r3 = r1 + r2, then LW with wait states on both accesses.
    run_instr(16'h7123, 1'b0, 0, 0);
    chk("add_pc", pc, 16'h0001);
    run_instr(16'h1215, 1'b0, 2, 2);

    // BEQ taken from pc 0 wraps to 0xFFFF; JUMP then lands at 0x0234.
    do_reset();
    run_instr(16'hA12E, 1'b1, 0, 0);
    chk("beq_taken_pc", pc, 16'hFFFF);
    run_instr(16'hB234, 1'b0, 0, 0);
    chk("jump_wrap_pc", pc, 16'h0234);
    for (int i = 0; i < 512; i++) run_instr(16'hA007, 1'b1, 0, 0);
    chk("walk_pc", pc, 16'h1234);
    run_instr(16'hB0FF, 1'b0, 0, 0);
    chk("jump_pc", pc, 16'h10FF);
    run_instr(16'h4123, 1'b0, 0, 1);

    // BEQ not taken.
    do_reset();
    run_instr(16'hA12E, 1'b0, 0, 0);
    chk("beq_not_taken_pc", pc, 16'h0001);

    // Random legal instruction stream.
    for (int i = 0; i < 80; i++) begin
      op    = 4'($urandom_range(1, 12));
      instr = {op, 12'($urandom)};
      run_instr(instr, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset while a load sits in MEM waiting for memory.
    alu_out = 16'h5A5A;
    fetch_instr(16'h1215, 0, cyc);
    step();
    step();
    chk("mem_pending_req", {15'd0, mem_req}, 16'd1);
    chk("mem_pending_addr", mem_addr, 16'h5A5A);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_req", {15'd0, mem_req}, 16'd0);
    chk("abort_pc", pc, 16'h0000);
    chk("abort_rf_we", {15'd0, rf_we}, 16'd0);
    mem_ready = 1'b1;
    mem_rdata = 16'h7777;
    step();
    mem_ready = 1'b0;
    chk("post_abort_req", {15'd0, mem_req}, 16'd1);
    chk("post_abort_addr", mem_addr, 16'h0000);
    chk("late_ready_ignored", ir, 16'h0000);
    exp_pc = 16'h0000;
    run_instr(16'h5321, 1'b0, 1, 0);

    // Illegal opcode traps until reset.
    fetch_instr(16'hF000, 0, cyc);
    chk("decode_not_illegal", {15'd0, illegal}, 16'd0);
    step();
    for (int i = 0; i < 20; i++) begin
      chk("trap_illegal", {15'd0, illegal}, 16'd1);
      chk("trap_no_req", {15'd0, mem_req}, 16'd0);
      step();
    end
    do_reset();
    chk("trap_cleared", {15'd0, illegal}, 16'd0);
    run_instr(16'hC3A5, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
